// File: rtl/sd_sector_responder.sv
// Responder for the core's sector handshake: moves one 512-byte sector between the
// core's sector buffer and a byte-wide backing store, one byte at a time.
module sd_sector_responder #(
  parameter int unsigned LBA_BITS  = 6,
  parameter int unsigned ACK_DELAY = 4,
  parameter int unsigned GAP       = 2
) (
  input  logic                  clk_sys,
  input  logic                  reset,
  input  logic [31:0]           sd_lba,
  input  logic                  sd_rd,
  input  logic                  sd_wr,
  output logic                  sd_ack,
  output logic [8:0]            sd_buff_addr,
  output logic [7:0]            sd_buff_dout,
  output logic                  sd_buff_wr,
  input  logic [7:0]            sd_buff_din,
  output logic [LBA_BITS+8:0]   store_addr,
  output logic                  store_rd,
  output logic                  store_wr,
  output logic [7:0]            store_wdata,
  input  logic [7:0]            store_rdata,
  input  logic                  store_ready,
  output logic                  busy,
  output logic                  err
);

  typedef enum logic [2:0] {
    StIdle, StAckWait, StRdReq, StRdPush, StWrAddr, StWrCap, StWrReq, StGapWait
  } state_e;

  state_e              state_q, state_d;
  logic [7:0]          cnt_q, cnt_d;
  logic [LBA_BITS-1:0] lba_q, lba_d;
  logic                dir_rd_q, dir_rd_d;
  logic                oor_q, oor_d;
  logic [8:0]          idx_q, idx_d;
  logic                sd_ack_q, sd_ack_d;
  logic [8:0]          sd_buff_addr_q, sd_buff_addr_d;
  logic [7:0]          sd_buff_dout_q, sd_buff_dout_d;
  logic                sd_buff_wr_q, sd_buff_wr_d;
  logic                store_rd_q, store_rd_d;
  logic                store_wr_q, store_wr_d;
  logic [7:0]          store_wdata_q, store_wdata_d;
  logic                busy_q, busy_d;
  logic                err_q, err_d;

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    lba_d          = lba_q;
    dir_rd_d       = dir_rd_q;
    oor_d          = oor_q;
    idx_d          = idx_q;
    sd_ack_d       = sd_ack_q;
    sd_buff_addr_d = sd_buff_addr_q;
    sd_buff_dout_d = sd_buff_dout_q;
    sd_buff_wr_d   = 1'b0;
    store_rd_d     = store_rd_q;
    store_wr_d     = store_wr_q;
    store_wdata_d  = store_wdata_q;
    err_d          = err_q;

    unique case (state_q)
      StIdle: begin
        if (sd_rd || sd_wr) begin
          lba_d    = sd_lba[LBA_BITS-1:0];
          dir_rd_d = sd_rd;
          oor_d    = |sd_lba[31:LBA_BITS];
          idx_d    = 9'd0;
          cnt_d    = 8'd0;
          state_d  = StAckWait;
          if (|sd_lba[31:LBA_BITS]) err_d = 1'b1;
        end
      end
      StAckWait: begin
        if (cnt_q == 8'(ACK_DELAY - 1)) begin
          sd_ack_d = 1'b1;
          cnt_d    = 8'd0;
          if (dir_rd_q) begin
            state_d    = StRdReq;
            store_rd_d = !oor_q;
          end else begin
            state_d        = StWrAddr;
            sd_buff_addr_d = idx_q;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      StRdReq: begin
        // Out-of-range sectors never touch the store and read back as erased.
        if (oor_q || store_ready) begin
          store_rd_d     = 1'b0;
          sd_buff_dout_d = oor_q ? 8'hFF : store_rdata;
          sd_buff_addr_d = idx_q;
          sd_buff_wr_d   = 1'b1;
          state_d        = StRdPush;
        end
      end
      StRdPush: begin
        if (idx_q == 9'd511) begin
          sd_ack_d = 1'b0;
          cnt_d    = 8'd0;
          state_d  = (GAP == 0) ? StIdle : StGapWait;
        end else begin
          idx_d      = idx_q + 9'd1;
          store_rd_d = !oor_q;
          state_d    = StRdReq;
        end
      end
      StWrAddr: state_d = StWrCap;
      StWrCap: begin
        // Buffer read data lags its address by one cycle.
        store_wdata_d = sd_buff_din;
        store_wr_d    = !oor_q;
        state_d       = StWrReq;
      end
      StWrReq: begin
        if (oor_q || store_ready) begin
          store_wr_d = 1'b0;
          if (idx_q == 9'd511) begin
            sd_ack_d = 1'b0;
            cnt_d    = 8'd0;
            state_d  = (GAP == 0) ? StIdle : StGapWait;
          end else begin
            idx_d          = idx_q + 9'd1;
            sd_buff_addr_d = idx_q + 9'd1;
            state_d        = StWrAddr;
          end
        end
      end
      StGapWait: begin
        if (cnt_q == 8'(GAP - 1)) begin
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = StIdle;
    endcase

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q        <= StIdle;
      cnt_q          <= 8'd0;
      lba_q          <= '0;
      dir_rd_q       <= 1'b0;
      oor_q          <= 1'b0;
      idx_q          <= 9'd0;
      sd_ack_q       <= 1'b0;
      sd_buff_addr_q <= 9'd0;
      sd_buff_dout_q <= 8'd0;
      sd_buff_wr_q   <= 1'b0;
      store_rd_q     <= 1'b0;
      store_wr_q     <= 1'b0;
      store_wdata_q  <= 8'd0;
      busy_q         <= 1'b0;
      err_q          <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      lba_q          <= lba_d;
      dir_rd_q       <= dir_rd_d;
      oor_q          <= oor_d;
      idx_q          <= idx_d;
      sd_ack_q       <= sd_ack_d;
      sd_buff_addr_q <= sd_buff_addr_d;
      sd_buff_dout_q <= sd_buff_dout_d;
      sd_buff_wr_q   <= sd_buff_wr_d;
      store_rd_q     <= store_rd_d;
      store_wr_q     <= store_wr_d;
      store_wdata_q  <= store_wdata_d;
      busy_q         <= busy_d;
      err_q          <= err_d;
    end
  end

  assign sd_ack       = sd_ack_q;
  assign sd_buff_addr = sd_buff_addr_q;
  assign sd_buff_dout = sd_buff_dout_q;
  assign sd_buff_wr   = sd_buff_wr_q;
  assign store_addr   = {lba_q, idx_q};
  assign store_rd     = store_rd_q;
  assign store_wr     = store_wr_q;
  assign store_wdata  = store_wdata_q;
  assign busy         = busy_q;
  assign err          = err_q;

endmodule

// File: tb/tb_sd_sector_responder.sv
// Directed bench for sd_sector_responder: behavioural store and sector buffer, a
// negedge monitor logging transfers, and a linear sequence of directed checks.
module tb_sd_sector_responder;
  localparam int unsigned LBA_BITS  = 6;
  localparam int unsigned ACK_DELAY = 4;
  localparam int unsigned GAP       = 2;

  logic        clk_sys = 1'b0;
  logic        reset   = 1'b1;
  logic [31:0] sd_lba  = 32'd0;
  logic        sd_rd   = 1'b0;
  logic        sd_wr   = 1'b0;
  logic        sd_ack;
  logic [8:0]  sd_buff_addr;
  logic [7:0]  sd_buff_dout;
  logic        sd_buff_wr;
  logic [7:0]  sd_buff_din = 8'd0;
  logic [14:0] store_addr;
  logic        store_rd;
  logic        store_wr;
  logic [7:0]  store_wdata;
  logic [7:0]  store_rdata;
  logic        store_ready;
  logic        busy;
  logic        err;

  int checks   = 0;
  int failures = 0;

  sd_sector_responder #(
    .LBA_BITS (LBA_BITS),
    .ACK_DELAY(ACK_DELAY),
    .GAP      (GAP)
  ) dut (
    .clk_sys     (clk_sys),
    .reset       (reset),
    .sd_lba      (sd_lba),
    .sd_rd       (sd_rd),
    .sd_wr       (sd_wr),
    .sd_ack      (sd_ack),
    .sd_buff_addr(sd_buff_addr),
    .sd_buff_dout(sd_buff_dout),
    .sd_buff_wr  (sd_buff_wr),
    .sd_buff_din (sd_buff_din),
    .store_addr  (store_addr),
    .store_rd    (store_rd),
    .store_wr    (store_wr),
    .store_wdata (store_wdata),
    .store_rdata (store_rdata),
    .store_ready (store_ready),
    .busy        (busy),
    .err         (err)
  );

  always #5 clk_sys = ~clk_sys;

  // Store model: fast mode completes combinationally, otherwise after cur_lat cycles.
  bit   fast     = 1'b0;
  bit   xor_mode = 1'b0;
  bit   stall_en = 1'b0;
  int   lat_norm = 2;
  int   cur_lat;
  int   scnt     = 0;
  logic ready_q  = 1'b0;

  assign cur_lat     = (stall_en && store_addr[8:0] == 9'd7) ? 50 : lat_norm;
  assign store_rdata = xor_mode ? (store_addr[7:0] ^ {2'b00, store_addr[14:9]}) : store_addr[7:0];
  assign store_ready = fast ? (store_rd | store_wr) : ready_q;

  always @(posedge clk_sys) begin
    if (reset || fast) begin
      ready_q <= 1'b0;
      scnt    <= 0;
    end else if ((store_rd || store_wr) && !ready_q) begin
      if (scnt >= cur_lat - 1) begin
        ready_q <= 1'b1;
        scnt    <= 0;
      end else begin
        scnt <= scnt + 1;
      end
    end else begin
      ready_q <= 1'b0;
    end
  end

  logic [7:0] buf_mem [512];
  always @(posedge clk_sys) sd_buff_din <= buf_mem[sd_buff_addr];

  // Transfer log and protocol monitors.
  logic [8:0]  push_addr [$];
  logic [7:0]  push_data [$];
  logic [14:0] rd_addr   [$];
  logic [14:0] wr_addr   [$];
  logic [7:0]  wr_data   [$];
  int          both_viol = 0;
  int          ack_viol  = 0;
  int          hold_viol = 0;
  logic        prev_rd   = 1'b0;
  logic        prev_rdy  = 1'b0;
  logic [14:0] prev_addr = 15'd0;

  always @(negedge clk_sys) begin
    if (sd_buff_wr) begin
      push_addr.push_back(sd_buff_addr);
      push_data.push_back(sd_buff_dout);
      if (!sd_ack) ack_viol <= ack_viol + 1;
    end
    if (store_rd && store_wr) both_viol <= both_viol + 1;
    if (store_rd && store_ready) rd_addr.push_back(store_addr);
    if (store_wr && store_ready) begin
      wr_addr.push_back(store_addr);
      wr_data.push_back(store_wdata);
    end
    if (!reset && prev_rd && !prev_rdy && (!store_rd || store_addr != prev_addr))
      hold_viol <= hold_viol + 1;
    prev_rd   <= store_rd;
    prev_rdy  <= store_ready;
    prev_addr <= store_addr;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ack(input logic lvl, input int budget, input string tag, output int n);
    n = 0;
    while (sd_ack !== lvl && n < budget) begin
      @(negedge clk_sys);
      n++;
    end
    if (sd_ack !== lvl) chk(tag, {31'd0, sd_ack}, {31'd0, lvl});
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int n = 0;
    while (busy !== 1'b0 && n < budget) begin
      @(negedge clk_sys);
      n++;
    end
    if (busy !== 1'b0) chk({tag, "_idle"}, {31'd0, busy}, 32'd0);
  endtask

  task automatic run_xfer(input logic [31:0] lba, input logic rd, input logic wr,
                          input string tag);
    int n;
    @(negedge clk_sys);
    sd_lba = lba;
    sd_rd  = rd;
    sd_wr  = wr;
    @(negedge clk_sys);
    sd_rd = 1'b0;
    sd_wr = 1'b0;
    wait_ack(1'b1, 20, {tag, "_ack_rise"}, n);
    wait_ack(1'b0, 5000, {tag, "_ack_fall"}, n);
    wait_idle(20, tag);
  endtask

  initial begin
    int n, m, bad, bp, br, bw, idx, sec;

    for (int i = 0; i < 512; i++) buf_mem[i] = ~i[7:0];

    // Reset state
    repeat (3) @(negedge clk_sys);
    chk("rst_sd_ack", {31'd0, sd_ack}, 32'd0);
    chk("rst_sd_buff_wr", {31'd0, sd_buff_wr}, 32'd0);
    chk("rst_store_rd", {31'd0, store_rd}, 32'd0);
    chk("rst_store_wr", {31'd0, store_wr}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_store_addr", {17'd0, store_addr}, 32'd0);
    reset = 1'b0;
    @(negedge clk_sys);

    // Load lba=3, store ready after 2 cycles
    lat_norm = 2;
    bp = push_addr.size();
    br = rd_addr.size();
    sd_lba = 32'd3;
    sd_rd  = 1'b1;
    @(negedge clk_sys);
    n = 1;
    sd_rd = 1'b0;
    while (!sd_ack && n < 20) begin
      @(negedge clk_sys);
      n++;
    end
    chk("load_ack_latency", 32'(n), 32'd5);
    wait_ack(1'b0, 5000, "load_ack_fall", n);
    m = 0;
    while (busy && m < 20) begin
      @(negedge clk_sys);
      m++;
    end
    chk("load_busy_gap", 32'(m), 32'(GAP));
    chk("load_push_count", 32'(push_addr.size() - bp), 32'd512);
    bad = 0;
    for (int k = 0; k < 512 && bp + k < push_addr.size(); k++)
      if (push_addr[bp+k] !== 9'(k) || push_data[bp+k] !== 8'(k)) bad++;
    chk("load_push_bad", 32'(bad), 32'd0);
    chk("load_rd_count", 32'(rd_addr.size() - br), 32'd512);
    bad = 0;
    for (int k = 0; k < 512 && br + k < rd_addr.size(); k++)
      if (rd_addr[br+k] !== 15'(32'h600 + k)) bad++;
    chk("load_rd_addr_bad", 32'(bad), 32'd0);
    chk("load_err", {31'd0, err}, 32'd0);

    // Save lba=0 from a buffer holding ~addr
    lat_norm = 1;
    bp = push_addr.size();
    bw = wr_addr.size();
    run_xfer(32'd0, 1'b0, 1'b1, "save");
    chk("save_wr_count", 32'(wr_addr.size() - bw), 32'd512);
    bad = 0;
    for (int k = 0; k < 512 && bw + k < wr_addr.size(); k++)
      if (wr_addr[bw+k] !== 15'(k) || wr_data[bw+k] !== ~k[7:0]) bad++;
    chk("save_wr_bad", 32'(bad), 32'd0);
    chk("save_no_push", 32'(push_addr.size() - bp), 32'd0);

    // 64-sector load, re-raising sd_rd right on each ack fall
    fast     = 1'b1;
    xor_mode = 1'b1;
    bp = push_addr.size();
    br = rd_addr.size();
    for (int s = 0; s < 64; s++) begin
      sd_lba = 32'(s);
      sd_rd  = 1'b1;
      wait_ack(1'b1, 20, "seq_ack_rise", n);
      sd_rd = 1'b0;
      wait_ack(1'b0, 2000, "seq_ack_fall", n);
    end
    wait_idle(20, "seq");
    chk("seq_push_count", 32'(push_addr.size() - bp), 32'd32768);
    bad = 0;
    for (int k = 0; k < 32768 && bp + k < push_addr.size(); k++) begin
      idx = k % 512;
      sec = k / 512;
      if (push_addr[bp+k] !== 9'(idx) || push_data[bp+k] !== (8'(idx) ^ 8'(sec))) bad++;
    end
    chk("seq_push_bad", 32'(bad), 32'd0);
    chk("seq_rd_count", 32'(rd_addr.size() - br), 32'd32768);
    bad = 0;
    for (int k = 0; k < 32768 && br + k < rd_addr.size(); k++)
      if (rd_addr[br+k] !== 15'(k)) bad++;
    chk("seq_rd_addr_bad", 32'(bad), 32'd0);
    xor_mode = 1'b0;

    // Out-of-range lba=64
    bp = push_addr.size();
    br = rd_addr.size();
    run_xfer(32'd64, 1'b1, 1'b0, "oor");
    chk("oor_push_count", 32'(push_addr.size() - bp), 32'd512);
    bad = 0;
    for (int k = 0; k < 512 && bp + k < push_addr.size(); k++)
      if (push_addr[bp+k] !== 9'(k) || push_data[bp+k] !== 8'hFF) bad++;
    chk("oor_push_bad", 32'(bad), 32'd0);
    chk("oor_no_store_rd", 32'(rd_addr.size() - br), 32'd0);
    chk("oor_err", {31'd0, err}, 32'd1);

    // sd_rd and sd_wr together: read wins
    bp = push_addr.size();
    br = rd_addr.size();
    bw = wr_addr.size();
    run_xfer(32'd5, 1'b1, 1'b1, "both");
    chk("both_push_count", 32'(push_addr.size() - bp), 32'd512);
    chk("both_rd_count", 32'(rd_addr.size() - br), 32'd512);
    chk("both_no_store_wr", 32'(wr_addr.size() - bw), 32'd0);
    chk("both_err_sticky", {31'd0, err}, 32'd1);

    // Reset at byte 100 of a save
    fast     = 1'b0;
    lat_norm = 1;
    bw = wr_addr.size();
    sd_lba = 32'd1;
    sd_wr  = 1'b1;
    @(negedge clk_sys);
    sd_wr = 1'b0;
    n = 0;
    while (wr_addr.size() - bw < 100 && n < 3000) begin
      @(negedge clk_sys);
      n++;
    end
    chk("rstmid_reached_byte100", 32'(wr_addr.size() - bw), 32'd100);
    reset = 1'b1;
    @(negedge clk_sys);
    chk("rstmid_sd_ack", {31'd0, sd_ack}, 32'd0);
    chk("rstmid_store_wr", {31'd0, store_wr}, 32'd0);
    chk("rstmid_busy", {31'd0, busy}, 32'd0);
    chk("rstmid_err", {31'd0, err}, 32'd0);
    reset = 1'b0;
    @(negedge clk_sys);

    // Store stalls 50 cycles at byte 7 of a load
    stall_en = 1'b1;
    lat_norm = 1;
    bp = push_addr.size();
    br = rd_addr.size();
    sd_lba = 32'd2;
    sd_rd  = 1'b1;
    @(negedge clk_sys);
    sd_rd = 1'b0;
    wait_ack(1'b1, 20, "stall_ack_rise", n);
    n = 0;
    while (!(store_rd && store_addr[8:0] == 9'd7) && n < 200) begin
      @(negedge clk_sys);
      n++;
    end
    chk("stall_reached_byte7", {23'd0, store_addr[8:0]}, 32'd7);
    bad = 0;
    for (int c = 0; c < 45; c++) begin
      @(negedge clk_sys);
      if (!(sd_ack && store_rd && store_addr == 15'h407)) bad++;
    end
    chk("stall_held_bad", 32'(bad), 32'd0);
    chk("stall_push_so_far", 32'(push_addr.size() - bp), 32'd7);
    wait_ack(1'b0, 5000, "stall_ack_fall", n);
    wait_idle(20, "stall");
    stall_en = 1'b0;
    chk("stall_push_count", 32'(push_addr.size() - bp), 32'd512);
    bad = 0;
    for (int k = 0; k < 512 && bp + k < push_addr.size(); k++)
      if (push_addr[bp+k] !== 9'(k) || push_data[bp+k] !== 8'(k)) bad++;
    chk("stall_push_bad", 32'(bad), 32'd0);
    chk("stall_rd_count", 32'(rd_addr.size() - br), 32'd512);

    chk("mon_strobes_both_high", 32'(both_viol), 32'd0);
    chk("mon_buff_wr_without_ack", 32'(ack_viol), 32'd0);
    chk("mon_store_rd_hold", 32'(hold_viol), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sd_sector_responder.md
Name: sd_sector_responder

Overview:
- Responder side of the core's sector handshake (sd_lba / sd_rd / sd_wr / sd_ack / sd_buff_*).
- Services the requests that the backup-RAM load/save sequencer issues, one 512-byte sector at a time.
- Each sector is moved between the core's sector buffer and a byte-wide backing store (SDRAM/DDR arbiter port).
- Lets the save flow run with a local store and acts as the HPS stand-in in simulation.

Parameters:
- LBA_BITS, 6: number of valid sector-index bits; 64 sectors = 32 KB.
- ACK_DELAY, 4: cycles from request acceptance to sd_ack rise (minimum 1).
- GAP, 2: idle cycles after sd_ack falls before a new request is accepted.

Ports:
- clk_sys  in  1  system clock
- reset  in  1  synchronous, active-high
- sd_lba  in  32  sector index, sampled at request acceptance
- sd_rd  in  1  level request: store -> core buffer (load)
- sd_wr  in  1  level request: core buffer -> store (save)
- sd_ack  out  1  high for the whole transfer
- sd_buff_addr  out  9  byte index within sector
- sd_buff_dout  out  8  byte written into core buffer
- sd_buff_wr  out  1  one-cycle write strobe into core buffer
- sd_buff_din  in  8  core buffer read data, valid 1 cycle after sd_buff_addr
- store_addr  out  LBA_BITS+9  {lba, byte index}
- store_rd  out  1  held until store_ready
- store_wr  out  1  held until store_ready
- store_wdata  out  8  write data
- store_rdata  in  8  read data, valid when store_ready=1
- store_ready  in  1  one-cycle completion strobe
- busy  out  1  state != IDLE
- err  out  1  sticky: out-of-range lba seen

Behaviour:
- Reset: all outputs 0; state=IDLE. A reset mid-transfer takes effect the next cycle: sd_ack, sd_buff_wr, store_rd and store_wr all drop. err clears only on reset.
- States: IDLE, ACKWAIT, RD_REQ, RD_PUSH, WR_ADDR, WR_CAP, WR_REQ, GAPWAIT.
- IDLE: when sd_rd|sd_wr, latch lba=sd_lba[LBA_BITS-1:0], dir (sd_rd wins if both are set), oor=|sd_lba[31:LBA_BITS], idx=0; go to ACKWAIT.
- ACKWAIT: count ACK_DELAY cycles, then sd_ack<=1 and go to RD_REQ or WR_ADDR. sd_ack stays 1 until after the last byte.
- Requests are level-sensitive in IDLE only. The initiator may drop sd_rd/sd_wr on the ack rise; the responder does not require them held. Requests seen outside IDLE are ignored.
- RD_REQ: assert store_rd with store_addr={lba,idx}. If oor, skip the store access and use data 0xFF. Wait for store_ready, capture store_rdata, go to RD_PUSH.
- RD_PUSH: sd_buff_addr=idx, sd_buff_dout=data, sd_buff_wr=1 for exactly one cycle. If idx==511, go to finish; else idx+1 and back to RD_REQ.
- WR_ADDR: drive sd_buff_addr=idx. WR_CAP (next cycle): sample sd_buff_din.
- WR_REQ: store_wr=1 with store_wdata until store_ready. If oor, the write is discarded and no store_wr is issued. Then idx==511 -> finish, else idx+1 and back to WR_ADDR.
- Finish: sd_ack<=0, go to GAPWAIT for GAP cycles, then IDLE. This guarantees the initiator sees a clean ack falling edge and can re-raise the next request.
- err <= 1 when an oor request is accepted.
- idx is 9-bit. Wrap from 511 never occurs because the transfer ends there.
- store_addr is always {lba, idx}. Strobes are never both high. Strobes are held stable while waiting, including when store_ready is delayed indefinitely.
- sd_buff_wr is only ever high while sd_ack=1.
- Latency per read byte: 2 cycles + store wait. Per write byte: 3 cycles + store wait.

Test Plan:
- Load, lba=3: single sd_rd pulse, store returns byte = addr[7:0] with ready after 2 cycles.
  - sd_ack rises 5 cycles after the request.
  - 512 sd_buff_wr pulses with addr 0..511 and dout = addr[7:0].
  - store_addr spans 0x600..0x7FF; ack falls; busy low GAP cycles later.
- Save, lba=0: core buffer preloaded with ~addr.
  - 512 store_wr with store_wdata = ~idx, taken from sd_buff_din one cycle after each address.
  - No sd_buff_wr during the save.
- Full 64-sector load sequence driven the way the backup sequencer does it (re-raise sd_rd on ack fall, lba+1).
  - All 32768 bytes delivered; no request is lost across the GAP window.
- sd_lba=64 with sd_rd: ack/transfer completes, all 512 bytes are 0xFF, no store_rd, err=1 until reset.
- sd_rd and sd_wr set in the same cycle: a read transfer is executed. Then reset asserted at byte 100 of a save: next cycle sd_ack=0, store_wr=0, busy=0, err=0.
- Store stalls store_ready for 50 cycles at byte 7: store_addr/store_rd held constant, sd_ack held 1, no extra sd_buff_wr.
